// File: rtl/pipe_stage_latch.sv
// Parametrised pipeline stage register: 2-entry skid buffer with valid/ready, flush and NOP bubbles.
// Optional performance counters (stall_cycles, bubble_cycles) enabled by defining STAGE_PERF_CNT_EN.
module pipe_stage_latch #(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned NUM_FIELDS = 2,
   parameter int unsigned IR_W       = 32,
   parameter int unsigned FLAG_W     = 1,
   parameter logic [IR_W-1:0] NOP_IR = '0
) (
   input  logic                         clock,
   input  logic                         clr_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic                         in_flush,
   input  logic [NUM_FIELDS*DATA_W-1:0] in_fields,
   input  logic [IR_W-1:0]              in_ir,
   input  logic [FLAG_W-1:0]            in_flags,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [NUM_FIELDS*DATA_W-1:0] out_fields,
   output logic [IR_W-1:0]              out_ir,
   output logic [FLAG_W-1:0]            out_flags
`ifdef STAGE_PERF_CNT_EN
   ,
   output logic [31:0]                  stall_cycles,
   output logic [31:0]                  bubble_cycles
`endif
);

   localparam int unsigned FW = NUM_FIELDS * DATA_W;

   typedef struct packed {
      logic [FW-1:0]     fields;
      logic [IR_W-1:0]   ir;
      logic [FLAG_W-1:0] flags;
   } entry_t;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_t;

   state_t state_q, state_d;
   entry_t m_q, m_d;
   entry_t s_q, s_d;
   logic   in_ready_q, in_ready_d;
   entry_t in_entry;
   logic   in_fire;
   logic   out_fire;

   assign in_entry = '{fields: in_fields, ir: in_ir, flags: in_flags};
   assign in_fire  = in_valid & in_ready_q;
   assign out_valid = (state_q != ST_EMPTY);
   assign out_fire = out_valid & out_ready;

   always_comb begin
      state_d = state_q;
      m_d     = m_q;
      s_d     = s_q;
      if (in_flush) begin
         state_d = ST_EMPTY;
      end else begin
         unique case (state_q)
            ST_EMPTY: begin
               if (in_fire) begin
                  m_d     = in_entry;
                  state_d = ST_ONE;
               end
            end
            ST_ONE: begin
               if (in_fire && out_fire) begin
                  m_d = in_entry;
               end else if (out_fire) begin
                  state_d = ST_EMPTY;
               end else if (in_fire) begin
                  s_d     = in_entry;
                  state_d = ST_TWO;
               end
            end
            ST_TWO: begin
               // in_ready is low here, so only the drain path exists.
               if (out_fire) begin
                  m_d     = s_q;
                  state_d = ST_ONE;
               end
            end
            default: state_d = ST_EMPTY;
         endcase
      end
      in_ready_d = (state_d != ST_TWO);
   end

   always_ff @(posedge clock or negedge clr_n) begin
      if (!clr_n) begin
         state_q    <= ST_EMPTY;
         in_ready_q <= 1'b0;
         // NOTE: the two data entries are cleared on reset so nothing stale can ever leak past the output gating.
         m_q        <= '0;
         s_q        <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the pre-edge values computed above.
         state_q    <= state_d;
         in_ready_q <= in_ready_d;
         m_q        <= m_d;
         s_q        <= s_d;
      end
   end

   assign in_ready   = in_ready_q;
   assign out_ir     = out_valid ? m_q.ir : NOP_IR;
   assign out_fields = out_valid ? m_q.fields : '0;
   assign out_flags  = out_valid ? m_q.flags : '0;

`ifdef STAGE_PERF_CNT_EN
   logic [31:0] stall_q, stall_d;
   logic [31:0] bubble_q, bubble_d;

   always_comb begin
      stall_d  = stall_q;
      bubble_d = bubble_q;
      if (out_valid && !out_ready && (stall_q != '1)) stall_d = stall_q + 32'd1;
      if (!out_valid && (bubble_q != '1)) bubble_d = bubble_q + 32'd1;
   end

   always_ff @(posedge clock or negedge clr_n) begin
      if (!clr_n) begin
         stall_q  <= '0;
         bubble_q <= '0;
      end else begin
         stall_q  <= stall_d;
         bubble_q <= bubble_d;
      end
   end

   assign stall_cycles  = stall_q;
   assign bubble_cycles = bubble_q;
`endif

endmodule

// File: tb/tb_pipe_stage_latch.sv
// Randomised self-checking bench for pipe_stage_latch against a queue-based reference model.
module tb_pipe_stage_latch;

   localparam int unsigned DATA_W     = 32;
   localparam int unsigned NUM_FIELDS = 2;
   localparam int unsigned IR_W       = 32;
   localparam int unsigned FLAG_W     = 1;
   localparam int unsigned FW         = NUM_FIELDS * DATA_W;
   localparam logic [IR_W-1:0] NOP    = 32'h0000_0013;

   logic              clock = 1'b0;
   logic              clr_n = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic              in_flush = 1'b0;
   logic [FW-1:0]     in_fields = '0;
   logic [IR_W-1:0]   in_ir = '0;
   logic [FLAG_W-1:0] in_flags = '0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [FW-1:0]     out_fields;
   logic [IR_W-1:0]   out_ir;
   logic [FLAG_W-1:0] out_flags;
`ifdef STAGE_PERF_CNT_EN
   logic [31:0]       stall_cycles;
   logic [31:0]       bubble_cycles;
`endif

   pipe_stage_latch #(
      .DATA_W(DATA_W), .NUM_FIELDS(NUM_FIELDS), .IR_W(IR_W), .FLAG_W(FLAG_W), .NOP_IR(NOP)
   ) dut (
      .clock(clock), .clr_n(clr_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_flush(in_flush),
      .in_fields(in_fields), .in_ir(in_ir), .in_flags(in_flags),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_fields(out_fields), .out_ir(out_ir), .out_flags(out_flags)
`ifdef STAGE_PERF_CNT_EN
      , .stall_cycles(stall_cycles), .bubble_cycles(bubble_cycles)
`endif
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [FW-1:0]     f;
      logic [IR_W-1:0]   ir;
      logic [FLAG_W-1:0] fl;
   } beat_t;

   beat_t       q[$];
   bit          m_ready = 1'b0;
   logic [31:0] m_stall = '0;
   logic [31:0] m_bubble = '0;
   int          vectors = 0;
   int          miscompares = 0;
   bit          seen_c = 1'b0;

   task automatic check(input string tag, input logic [95:0] act, input logic [95:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic check_outputs();
      bit v;
      v = (q.size() != 0);
      check("out_valid", 96'(out_valid), 96'(v));
      check("in_ready", 96'(in_ready), 96'(m_ready));
      check("out_ir", 96'(out_ir), v ? 96'(q[0].ir) : 96'(NOP));
      check("out_fields", 96'(out_fields), v ? 96'(q[0].f) : 96'(0));
      check("out_flags", 96'(out_flags), v ? 96'(q[0].fl) : 96'(0));
`ifdef STAGE_PERF_CNT_EN
      check("stall_cycles", 96'(stall_cycles), 96'(m_stall));
      check("bubble_cycles", 96'(bubble_cycles), 96'(m_bubble));
`endif
   endtask

   // One clock: compare at the falling edge, advance the model, return just after the rising edge.
   task automatic cycle();
      bit    in_fire, out_fire;
      beat_t b;
      @(negedge clock);
      check_outputs();
      if (out_valid && out_ir == 32'hC) seen_c = 1'b1;
      if (clr_n) begin
         if (q.size() != 0 && !out_ready && m_stall != '1) m_stall++;
         if (q.size() == 0 && m_bubble != '1) m_bubble++;
         if (in_flush) begin
            q.delete();
            m_ready = 1'b1;
         end else begin
            in_fire  = in_valid && m_ready;
            out_fire = (q.size() != 0) && out_ready;
            if (out_fire) void'(q.pop_front());
            if (in_fire) begin
               b.f = in_fields; b.ir = in_ir; b.fl = in_flags;
               q.push_back(b);
            end
            m_ready = (q.size() < 2);
         end
      end
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input bit v, input logic [IR_W-1:0] ir, input bit fl, input bit ordy);
      in_valid  = v;
      in_ir     = ir;
      in_flush  = fl;
      out_ready = ordy;
      in_fields = {$urandom, $urandom};
      in_flags  = FLAG_W'($urandom);
   endtask

   task automatic do_reset();
      clr_n = 1'b0;
      #1;
      q.delete();
      m_ready  = 1'b0;
      m_stall  = '0;
      m_bubble = '0;
      check("rst_out_valid", 96'(out_valid), 96'(0));
      check("rst_out_ir", 96'(out_ir), 96'(NOP));
      check("rst_in_ready", 96'(in_ready), 96'(0));
      cycle();
      clr_n = 1'b1;
   endtask

   initial begin
      drive(0, 0, 0, 0);
      #2;
      do_reset();
      cycle();
      cycle();

      // Streaming 1..8 with the sink always ready.
      for (int i = 1; i <= 8; i++) begin
         drive(1, IR_W'(i), 0, 1);
         cycle();
         check("stream_ready", 96'(in_ready), 96'(1));
      end
      drive(0, 0, 0, 1);
      cycle();
      cycle();

      // Backpressure: A in M, B to skid, C held at the input, then drain.
      drive(1, 32'hA, 0, 0); cycle();
      drive(1, 32'hB, 0, 0); cycle();
      check("bp_two_ready", 96'(in_ready), 96'(0));
      drive(1, 32'hC, 0, 0); cycle(); cycle();
      in_ready_drain: for (int i = 0; i < 5; i++) begin
         out_ready = 1'b1;
         if (i >= 2) in_valid = 1'b0;
         cycle();
      end
      drive(0, 0, 0, 1); cycle();

      // Simultaneous fire in ONE: M=5 replaced by 6.
      drive(1, 32'h5, 0, 0); cycle();
      drive(1, 32'h6, 0, 1); cycle();
      check("sim_ir", 96'(out_ir), 96'(32'h6));
      check("sim_ready", 96'(in_ready), 96'(1));
      drive(0, 0, 0, 1); cycle();

      // Flush while TWO, with IR 0xC offered at the same edge.
      seen_c = 1'b0;
      drive(1, 32'h1A, 0, 0); cycle();
      drive(1, 32'h1B, 0, 0); cycle();
      drive(1, 32'hC, 1, 0); cycle();
      check("flush_valid", 96'(out_valid), 96'(0));
      check("flush_ir", 96'(out_ir), 96'(NOP));
      check("flush_ready", 96'(in_ready), 96'(1));
      drive(0, 0, 0, 1);
      for (int i = 0; i < 4; i++) cycle();
      check("flush_no_c", 96'(seen_c), 96'(0));

      // Asynchronous reset between edges while TWO.
      drive(1, 32'hA, 0, 0); cycle();
      drive(1, 32'hB, 0, 0); cycle();
      drive(0, 0, 0, 0);
      #2;
      do_reset();
      check("post_rst_ready", 96'(in_ready), 96'(0));
      cycle();
      check("rise_ready", 96'(in_ready), 96'(1));

`ifdef STAGE_PERF_CNT_EN
      // Saturation of the stall counter.
      drive(1, 32'h77, 0, 0); cycle();
      drive(0, 0, 0, 0);
      force dut.stall_q = 32'hFFFF_FFFE;
      #1;
      release dut.stall_q;
      m_stall = 32'hFFFF_FFFE;
      for (int i = 0; i < 3; i++) cycle();
      check("stall_sat", 96'(stall_cycles), 96'(32'hFFFF_FFFF));
      drive(0, 0, 0, 1); cycle();
`endif

      // Random traffic with occasional flushes.
      for (int i = 0; i < 3000; i++) begin
         drive(($urandom % 4) != 0, $urandom, ($urandom % 40) == 0, ($urandom % 3) != 0);
         cycle();
      end
      drive(0, 0, 0, 1);
      for (int i = 0; i < 4; i++) cycle();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
